key_expand_iter: RTL and testbench

KEY_EXPAND_ITER -- requirements
Module: key_expand_iter

---
 rtl/aes_pkg.sv | 55 +++++
 rtl/sub_word.sv | 14 +
 rtl/key_expand_iter.sv | 160 ++++++++++++++++
 tb/tb_key_expand_iter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: S-box table, key-length legality,
// derived schedule sizes, byte/word helpers and the expander FSM states.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } ks_state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic bit key_bits_legal(input int kb);
        return (kb == 32'sd128) || (kb == 32'sd192) || (kb == 32'sd256);
    endfunction

    function automatic int nk_of(input int kb);
        return kb / 32'sd32;
    endfunction

    function automatic int nr_of(input int kb);
        return nk_of(kb) + 32'sd6;
    endfunction

    function automatic int nw_of(input int kb);
        return 32'sd4 * (nr_of(kb) + 32'sd1);
    endfunction

    // GF(2^8) doubling with the AES reduction polynomial
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/sub_word.sv
// Four parallel S-box lookups on a 32-bit word.
module sub_word
    import aes_pkg::*;
(
    input  logic [31:0] data,
    output logic [31:0] result
);

    // Byte-wise substitution, byte order preserved
    always_comb begin
        result = {SBOX[data[31:24]], SBOX[data[23:16]], SBOX[data[15:8]], SBOX[data[7:0]]};
    end

endmodule

// File: rtl/key_expand_iter.sv
// Iterative AES key expansion: one schedule word per clock into a flat
// register array, with round keys readable as soon as their words exist.
module key_expand_iter
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 32'sd128
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic [0:KEY_BITS-1] key_in,
    input  logic                key_valid,
    output logic                key_ready,
    input  logic [3:0]          rk_idx,
    output logic [0:127]        rk_out,
    output logic                rk_valid,
    output logic                done
);

    localparam int NK = nk_of(KEY_BITS);
    localparam int NR = nr_of(KEY_BITS);
    localparam int NW = nw_of(KEY_BITS);
    localparam int IW = $clog2(NW + 32'sd1);

    if (!key_bits_legal(KEY_BITS)) begin : g_bad_key_bits
        $error("key_expand_iter: KEY_BITS must be 128, 192 or 256");
    end

    ks_state_t     state_r;
    ks_state_t     state_nx_s;
    logic [31:0]   w_r [NW];
    logic [IW-1:0] i_r;
    logic [2:0]    phase_r;
    logic [7:0]    rcon_r;
    logic          done_r;

    logic          accept_s;
    logic          last_s;
    logic          rot_phase_s;
    logic          sub_phase_s;
    logic [IW-1:0] prev_idx_s;
    logic [IW-1:0] back_idx_s;
    logic [31:0]   prev_s;
    logic [31:0]   back_s;
    logic [31:0]   sub_in_s;
    logic [31:0]   sub_out_s;
    logic [31:0]   temp_s;
    logic [31:0]   new_word_s;
    logic [IW-1:0] rk_base_s;
    logic [IW:0]   rk_need_s;
    logic          rk_in_range_s;

    assign accept_s = key_valid & key_ready;
    assign last_s   = (state_r == EXPAND) && (i_r == IW'(NW - 32'sd1));
    assign done     = done_r;

    // Next-state and handshake decode
    always_comb begin
        state_nx_s = state_r;
        key_ready  = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                key_ready = 1'b1;
                if (key_valid) begin
                    state_nx_s = EXPAND;
                end else begin
                    state_nx_s = state_r;
                end
            end
            EXPAND: begin
                if (last_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = EXPAND;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // phase_r tracks i mod NK, so no divider is needed to pick the word transform
    always_comb begin
        prev_idx_s  = i_r - IW'(32'sd1);
        back_idx_s  = i_r - IW'(NK);
        prev_s      = w_r[prev_idx_s];
        back_s      = w_r[back_idx_s];
        rot_phase_s = (phase_r == 3'd0);
        sub_phase_s = (NK == 32'sd8) && (phase_r == 3'd4);
        sub_in_s    = rot_phase_s ? rot_word(prev_s) : prev_s;
        if (rot_phase_s) begin
            temp_s = sub_out_s ^ {rcon_r, 24'h000000};
        end else if (sub_phase_s) begin
            temp_s = sub_out_s;
        end else begin
            temp_s = prev_s;
        end
        new_word_s = back_s ^ temp_s;
    end

    sub_word u_sub_word (
        .data   (sub_in_s),
        .result (sub_out_s)
    );

    // Word storage, counters and done flag
    always_ff @(posedge clk) begin
        if (rst) begin
            i_r     <= '0;
            phase_r <= 3'd0;
            rcon_r  <= 8'h01;
            done_r  <= 1'b0;
            for (int j = 32'sd0; j < NW; j++) begin
                w_r[j] <= 32'h00000000;
            end
        end else if (accept_s) begin
            for (int j = 32'sd0; j < NK; j++) begin
                w_r[j] <= key_in[32'sd32 * j +: 32'sd32];
            end
            i_r     <= IW'(NK);
            phase_r <= 3'd0;
            rcon_r  <= 8'h01;
            done_r  <= 1'b0;
        end else if (state_r == EXPAND) begin
            w_r[i_r] <= new_word_s;
            i_r      <= i_r + IW'(32'sd1);
            phase_r  <= (phase_r == 3'(NK - 32'sd1)) ? 3'd0 : phase_r + 3'd1;
            rcon_r   <= rot_phase_s ? xtime(rcon_r) : rcon_r;
            done_r   <= last_s;
        end
    end

    // Round-key read port; a round is valid once word 4*rk_idx+3 has been written
    always_comb begin
        rk_base_s     = IW'({rk_idx, 2'b00});
        rk_need_s     = {1'b0, rk_base_s} + (IW + 1)'(32'sd4);
        rk_in_range_s = (rk_idx <= 4'(NR));
        rk_out        = 128'h0;
        rk_valid      = 1'b0;
        if (rk_in_range_s) begin
            rk_out   = {w_r[rk_base_s], w_r[rk_base_s + IW'(32'sd1)],
                        w_r[rk_base_s + IW'(32'sd2)], w_r[rk_base_s + IW'(32'sd3)]};
            rk_valid = ({1'b0, i_r} >= rk_need_s) || (state_r == DONE);
        end else begin
            rk_out   = 128'h0;
            rk_valid = 1'b0;
        end
    end

endmodule

// File: tb/tb_key_expand_iter.sv
// Bench for key_expand_iter: three key lengths side by side, vector table of
// round keys, plus timing sequences for progressive validity, busy, restart and reset.
module tb_key_expand_iter;
    import aes_pkg::*;

    localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         key_valid = 1'b0;
    logic [3:0]   rk_idx = 4'd0;
    logic [0:127] key_a = '0;
    logic [0:191] key_b = '0;
    logic [0:255] key_c = '0;
    logic         ready_a, ready_b, ready_c;
    logic         valid_a, valid_b, valid_c;
    logic         done_a, done_b, done_c;
    logic [0:127] rk_a, rk_b, rk_c;

    always #5 clk = ~clk;

    key_expand_iter #(.KEY_BITS(128)) u_a (.clk(clk), .rst(rst), .key_in(key_a), .key_valid(key_valid),
        .key_ready(ready_a), .rk_idx(rk_idx), .rk_out(rk_a), .rk_valid(valid_a), .done(done_a));
    key_expand_iter #(.KEY_BITS(192)) u_b (.clk(clk), .rst(rst), .key_in(key_b), .key_valid(key_valid),
        .key_ready(ready_b), .rk_idx(rk_idx), .rk_out(rk_b), .rk_valid(valid_b), .done(done_b));
    key_expand_iter #(.KEY_BITS(256)) u_c (.clk(clk), .rst(rst), .key_in(key_c), .key_valid(key_valid),
        .key_ready(ready_c), .rk_idx(rk_idx), .rk_out(rk_c), .rk_valid(valid_c), .done(done_c));

    typedef struct { string name; logic [128:0] exp; } sb_t;
    typedef struct { int dut; logic [3:0] idx; logic [128:0] exp; } vec_t;

    sb_t  sb_q[$];
    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic sb_push(input string name, input logic [128:0] exp);
        sb_t e;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input logic [128:0] act);
        sb_t e;
        n_vec++;
        if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: got %h with nothing expected", act);
        end else begin
            e = sb_q.pop_front();
            if (act !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %h, want %h", e.name, act, e.exp);
            end
        end
    endtask

    task automatic chk(input string name, input logic [128:0] act, input logic [128:0] exp);
        sb_push(name, exp);
        sb_check(act);
    endtask

    function automatic logic [128:0] obs(input int d);
        case (d)
            0:       return {valid_a, rk_a};
            1:       return {valid_b, rk_b};
            default: return {valid_c, rk_c};
        endcase
    endfunction

    function automatic logic [31:0] sub4(input logic [31:0] t);
        return {SBOX[t[31:24]], SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]]};
    endfunction

    // Straightforward FIPS-197 schedule; key is left-justified in 256 bits
    function automatic logic [127:0] ref_rk(input logic [255:0] key, input int nk, input int r);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int          nw;
        nw = 4 * (nk + 7);
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
        for (int i = nk; i < nw; i++) begin
            t = w[i - 1];
            if (i % nk == 0) begin
                t  = sub4({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk == 8 && i % 8 == 4) begin
                t = sub4(t);
            end
            w[i] = w[i - nk] ^ t;
        end
        return {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endfunction

    task automatic launch();
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    // Runs up to 60 cycles after an accept, recording the cycle done first rises
    task automatic run(input int reset_at, input int hold, input bit prog,
                       output int l_a, output int l_b, output int l_c);
        l_a = -1;
        l_b = -1;
        l_c = -1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            if (done_a && l_a < 0) l_a = c;
            if (done_b && l_b < 0) l_b = c;
            if (done_c && l_c < 0) l_c = c;
            if (c == 5) chk("busy_ready_low", 129'(ready_a), 129'(0));
            if (prog && c == 3) chk("rk1_valid_c3", 129'(valid_a), 129'(0));
            if (prog && c == 4) chk("rk1_at_c4", obs(0), {1'b1, 128'ha0fafe1788542cb123a339392a6c7605});
            if (c == hold) key_valid = 1'b0;
            if (c == reset_at) rst = 1'b1;
            if (reset_at > 0 && c == reset_at + 1) begin
                rst = 1'b0;
                chk("reset_mid_ready", 129'(ready_a), 129'(1));
                chk("reset_mid_done", 129'(done_a), 129'(0));
            end
        end
    endtask

    int l_a, l_b, l_c;
    logic [127:0] fips [11];

    initial begin
        fips = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
                 128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
                 128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
                 128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
                 128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
                 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        for (int r = 0; r < 16; r++) begin
            vecs.push_back('{0, 4'(r), (r <= 10) ? {1'b1, fips[r]} : 129'(0)});
            vecs.push_back('{1, 4'(r), (r < 12) ? {1'b1, ref_rk({K192, 64'h0}, 6, r)} :
                             (r == 12) ? {1'b1, 128'he98ba06f448c773c8ecc720401002202} : 129'(0)});
            vecs.push_back('{2, 4'(r), (r < 14) ? {1'b1, ref_rk(K256, 8, r)} :
                             (r == 14) ? {1'b1, 128'hfe4890d1e6188d0b046df344706c631e} : 129'(0)});
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_ready", 129'(ready_a), 129'(1));
        chk("reset_done", 129'({done_a, done_b, done_c}), 129'(0));
        chk("reset_rk0", obs(0), 129'(0));
        rk_idx = 4'd10;
        #1;
        chk("reset_rk10", obs(2), 129'(0));

        // Main expansion with key_valid held (and key_in scrambled) through EXPAND
        key_a = K128;
        key_b = K192;
        key_c = K256;
        rk_idx = 4'd1;
        launch();
        key_valid = 1'b1;
        key_a = {$urandom, $urandom, $urandom, $urandom};
        key_b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        key_c = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        run(0, 10, 1'b1, l_a, l_b, l_c);
        chk("latency_128", 129'(l_a), 129'(40));
        chk("latency_192", 129'(l_b), 129'(46));
        chk("latency_256", 129'(l_c), 129'(52));

        // Round-key table
        foreach (vecs[k]) begin
            rk_idx = vecs[k].idx;
            sb_push($sformatf("rk_dut%0d_idx%0d", vecs[k].dut, vecs[k].idx), vecs[k].exp);
            #1;
            sb_check(obs(vecs[k].dut));
        end
        @(posedge clk);
        #1;

        // Restart from DONE with the all-zero key
        key_a = '0;
        rk_idx = 4'd10;
        launch();
        chk("restart_done_low", 129'(done_a), 129'(0));
        chk("restart_rk10_invalid", 129'(valid_a), 129'(0));
        rk_idx = 4'd0;
        #1;
        chk("restart_rk0", obs(0), 129'({1'b1, 128'h0}));
        rk_idx = 4'd1;
        run(0, 0, 1'b0, l_a, l_b, l_c);
        chk("restart_latency", 129'(l_a), 129'(40));
        rk_idx = 4'd10;
        #1;
        chk("zero_key_rk10", obs(0), {1'b1, ref_rk({128'h0, 128'h0}, 4, 10)});

        // Reset at cycle 20 of EXPAND, then a fresh key
        key_a = K128;
        launch();
        run(20, 0, 1'b0, l_a, l_b, l_c);
        chk("reset_no_done", 129'({l_a == -1, l_b == -1, l_c == -1}), 129'(7));
        chk("reset_abandon_ready", 129'(ready_a), 129'(1));
        chk("reset_abandon_rk10", obs(0), 129'(0));
        launch();
        run(0, 0, 1'b0, l_a, l_b, l_c);
        chk("fresh_latency", 129'(l_a), 129'(40));
        chk("fresh_rk10", obs(0), {1'b1, fips[10]});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
